// File: rtl/commit_trace_pkg.sv
// Commit trace shared types: FIFO entry layout and FSM state encodings.
// Optional build macro: COMMIT_TRACE_X0_FILTER_EN (used by commit_trace_tx).
package commit_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        brk;
    logic        ivd;
  } commit_entry_t;

  localparam int COMMIT_ENTRY_W = $bits(commit_entry_t);

  typedef enum logic {
    EMIT_IDLE,
    EMIT_GAP
  } emit_state_e;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_DRAIN,
    CTRL_HALT
  } ctrl_state_e;

  function automatic logic is_stop(
    input commit_entry_t e
  );
    return e.brk | e.ivd;
  endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Commit entry FIFO: synchronous write, combinational head read.
// DEPTH must be a power of two so the pointers wrap for free.
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = commit_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  T     i_wdata,
  input  logic i_pop,
  output T     o_rdata,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: buffers WB retires, replays them as debugger pulses.
// Build macro COMMIT_TRACE_X0_FILTER_EN suppresses GPR writes to x0.
module commit_trace_tx
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_rd_wen,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_rd_wdata,
  input  logic        wb_brk,
  input  logic        wb_ivd,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_inst,
  output logic        dbg_done,
  output logic        dbg_gpr_wen,
  output logic [31:0] dbg_gpr_waddr,
  output logic [31:0] dbg_gpr_wdata,
  output logic        dbg_brk,
  output logic        dbg_ivd,
  output logic        dbg_halted
);

  commit_entry_t w_wentry;
  commit_entry_t w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_gpr_wen;
  logic          w_gpr_upd;

  emit_state_e   r_emit;
  emit_state_e   w_emit_nxt;
  ctrl_state_e   r_ctrl;
  ctrl_state_e   w_ctrl_nxt;

  logic [31:0]   r_pc;
  logic [31:0]   r_inst;
  logic          r_done;
  logic          r_gpr_wen;
  logic [31:0]   r_gpr_waddr;
  logic [31:0]   r_gpr_wdata;
  logic          r_brk;
  logic          r_ivd;
  logic          r_halted;

  assign w_wentry = '{
    pc:       wb_pc,
    inst:     wb_inst,
    rd_wen:   wb_rd_wen,
    rd_addr:  wb_rd_addr,
    rd_wdata: wb_rd_wdata,
    brk:      wb_brk,
    ivd:      wb_ivd
  };

  assign wb_ready = !w_full && (r_ctrl == CTRL_RUN);
  assign w_push   = wb_valid && wb_ready;

  commit_trace_fifo #(
    .DEPTH (DEPTH),
    .T     (commit_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_emit <= EMIT_IDLE;
      r_ctrl <= CTRL_RUN;
    end else begin
      r_emit <= w_emit_nxt;
      r_ctrl <= w_ctrl_nxt;
    end
  end

  // Every pop is followed by a GAP cycle so dbg_done always falls between commits.
  always_comb begin
    w_emit_nxt = r_emit;
    w_pop      = 1'b0;
    unique case (r_emit)
      EMIT_IDLE: begin
        if (!w_empty && r_ctrl != CTRL_HALT) begin
          w_pop      = 1'b1;
          w_emit_nxt = EMIT_GAP;
        end
      end
      EMIT_GAP: w_emit_nxt = EMIT_IDLE;
      default:  w_emit_nxt = EMIT_IDLE;
    endcase
  end

  always_comb begin
    w_ctrl_nxt = r_ctrl;
    unique case (r_ctrl)
      CTRL_RUN: begin
        if (w_push && is_stop(w_wentry)) w_ctrl_nxt = CTRL_DRAIN;
      end
      CTRL_DRAIN: begin
        if (w_pop && is_stop(w_head)) w_ctrl_nxt = CTRL_HALT;
      end
      CTRL_HALT: w_ctrl_nxt = CTRL_HALT;
      default:   w_ctrl_nxt = CTRL_RUN;
    endcase
  end

`ifdef COMMIT_TRACE_X0_FILTER_EN
  assign w_gpr_upd = (w_head.rd_addr != 5'd0);
  assign w_gpr_wen = w_head.rd_wen && w_gpr_upd;
`else
  assign w_gpr_upd = 1'b1;
  assign w_gpr_wen = w_head.rd_wen;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= '0;
      r_inst      <= '0;
      r_done      <= 1'b0;
      r_gpr_wen   <= 1'b0;
      r_gpr_waddr <= '0;
      r_gpr_wdata <= '0;
      r_brk       <= 1'b0;
      r_ivd       <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_done    <= w_pop;
      r_gpr_wen <= w_pop && w_gpr_wen;
      r_brk     <= w_pop && w_head.brk;
      r_ivd     <= w_pop && w_head.ivd;
      r_halted  <= r_halted || (r_ctrl == CTRL_HALT);
      if (w_pop) begin
        r_pc   <= w_head.pc;
        r_inst <= w_head.inst;
        if (w_gpr_upd) begin
          r_gpr_waddr <= {27'd0, w_head.rd_addr};
          r_gpr_wdata <= w_head.rd_wdata;
        end
      end
    end
  end

  assign dbg_pc        = r_pc;
  assign dbg_inst      = r_inst;
  assign dbg_done      = r_done;
  assign dbg_gpr_wen   = r_gpr_wen;
  assign dbg_gpr_waddr = r_gpr_waddr;
  assign dbg_gpr_wdata = r_gpr_wdata;
  assign dbg_brk       = r_brk;
  assign dbg_ivd       = r_ivd;
  assign dbg_halted    = r_halted;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx (DEPTH=4).
// Honours COMMIT_TRACE_X0_FILTER_EN for the x0 write case.
module tb_commit_trace_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_inst = '0;
  logic        wb_rd_wen = 1'b0;
  logic [4:0]  wb_rd_addr = '0;
  logic [31:0] wb_rd_wdata = '0;
  logic        wb_brk = 1'b0;
  logic        wb_ivd = 1'b0;
  logic [31:0] dbg_pc;
  logic [31:0] dbg_inst;
  logic        dbg_done;
  logic        dbg_gpr_wen;
  logic [31:0] dbg_gpr_waddr;
  logic [31:0] dbg_gpr_wdata;
  logic        dbg_brk;
  logic        dbg_ivd;
  logic        dbg_halted;

  int tests = 0;
  int fails = 0;
  int b2b = 0;
  logic prev_done = 1'b0;
  logic saw_stall = 1'b0;
  logic [31:0] q_pc[$];

  commit_trace_tx #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_pc         (wb_pc),
    .wb_inst       (wb_inst),
    .wb_rd_wen     (wb_rd_wen),
    .wb_rd_addr    (wb_rd_addr),
    .wb_rd_wdata   (wb_rd_wdata),
    .wb_brk        (wb_brk),
    .wb_ivd        (wb_ivd),
    .dbg_pc        (dbg_pc),
    .dbg_inst      (dbg_inst),
    .dbg_done      (dbg_done),
    .dbg_gpr_wen   (dbg_gpr_wen),
    .dbg_gpr_waddr (dbg_gpr_waddr),
    .dbg_gpr_wdata (dbg_gpr_wdata),
    .dbg_brk       (dbg_brk),
    .dbg_ivd       (dbg_ivd),
    .dbg_halted    (dbg_halted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dbg_done) begin
      q_pc.push_back(dbg_pc);
      if (prev_done) b2b++;
    end
    prev_done = dbg_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                      input logic wen, input logic [4:0] rd,
                      input logic [31:0] wd, input logic brk, input logic ivd);
    int n = 0;
    wb_valid = 1'b1;
    wb_pc = pc;
    wb_inst = inst;
    wb_rd_wen = wen;
    wb_rd_addr = rd;
    wb_rd_wdata = wd;
    wb_brk = brk;
    wb_ivd = ivd;
    while (!wb_ready && n < 50) begin
      saw_stall = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("push_accept", 32'(n < 50), 32'd1);
    @(negedge clk);
    wb_valid = 1'b0;
    wb_brk = 1'b0;
    wb_ivd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    wb_valid = 1'b0;
    repeat (2) @(negedge clk);
    q_pc.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  logic found;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t1_ctl", {26'd0, dbg_done, dbg_gpr_wen, dbg_brk, dbg_ivd,
                     dbg_halted, wb_ready}, 32'h1);
      chk("t1_data", dbg_pc | dbg_inst | dbg_gpr_waddr | dbg_gpr_wdata, 32'h0);
    end

    // 2: single commit
    push(32'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_done", dbg_done, 1);
    chk("t2_wen", dbg_gpr_wen, 1);
    chk("t2_pc", dbg_pc, 32'h8000_0000);
    chk("t2_inst", dbg_inst, 32'h0010_0093);
    chk("t2_waddr", dbg_gpr_waddr, 32'd1);
    chk("t2_wdata", dbg_gpr_wdata, 32'd1);
    chk("t2_brk", dbg_brk, 0);
    @(negedge clk);
    chk("t2_done_lo", dbg_done, 0);
    chk("t2_wen_lo", dbg_gpr_wen, 0);
    chk("t2_pc_held", dbg_pc, 32'h8000_0000);
    repeat (3) @(negedge clk);

    // 3: ten back-to-back commits through a 4-deep FIFO
    q_pc.delete();
    saw_stall = 1'b0;
    for (int i = 0; i < 10; i++)
      push(32'h1000 + 32'(4 * i), 32'h13, 1'b1, 5'd2, 32'(i), 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    chk("t3_stall", 32'(saw_stall), 32'd1);
    chk("t3_count", q_pc.size(), 10);
    chk("t3_gaps", b2b, 0);
    for (int i = 0; i < 10; i++)
      chk("t3_order", (i < q_pc.size()) ? q_pc[i] : 32'hFFFF_FFFF,
          32'h1000 + 32'(4 * i));

    // 4: A, B, then ebreak C
    q_pc.delete();
    push(32'h8000_0008, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    push(32'h8000_000C, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    push(32'h8000_0010, 32'h0010_0073, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("t4_ready_drop", wb_ready, 0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (dbg_done && dbg_pc == 32'h8000_0010) found = 1'b1;
    end
    chk("t4_found", found, 1);
    chk("t4_brk", dbg_brk, 1);
    chk("t4_ivd", dbg_ivd, 0);
    chk("t4_halt_pre", dbg_halted, 0);
    @(negedge clk);
    chk("t4_halted", dbg_halted, 1);
    chk("t4_done_lo", dbg_done, 0);
    wb_valid = 1'b1;
    wb_pc = 32'h9999_0000;
    repeat (10) @(negedge clk);
    chk("t4_ready_hold", wb_ready, 0);
    wb_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_count", q_pc.size(), 3);
    chk("t4_a", (q_pc.size() > 0) ? q_pc[0] : 32'hFFFF_FFFF, 32'h8000_0008);
    chk("t4_b", (q_pc.size() > 1) ? q_pc[1] : 32'hFFFF_FFFF, 32'h8000_000C);
    chk("t4_c", (q_pc.size() > 2) ? q_pc[2] : 32'hFFFF_FFFF, 32'h8000_0010);
    chk("t4_halt_stay", dbg_halted, 1);

    // 4b: brk and ivd together
    do_reset();
    chk("t4b_rst_ready", wb_ready, 1);
    chk("t4b_rst_halt", dbg_halted, 0);
    push(32'h200, 32'h0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t4b_both", {30'd0, dbg_brk, dbg_ivd}, 32'h3);
    chk("t4b_done", dbg_done, 1);
    @(negedge clk);
    chk("t4b_halted", dbg_halted, 1);

    // 5: write to x0
    do_reset();
    push(32'h300, 32'h0DE0_0013, 1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_done", dbg_done, 1);
`ifdef COMMIT_TRACE_X0_FILTER_EN
    chk("t5_wen", dbg_gpr_wen, 0);
    chk("t5_wdata", dbg_gpr_wdata, 32'h0);
`else
    chk("t5_wen", dbg_gpr_wen, 1);
    chk("t5_waddr", dbg_gpr_waddr, 32'h0);
    chk("t5_wdata", dbg_gpr_wdata, 32'h0000_DEAD);
`endif

    // 6: reset with three queued entries and dbg_done high
    do_reset();
    for (int i = 0; i < 6; i++)
      push(32'h4000 + 32'(4 * i), 32'h13, 1'b1, 5'd3, 32'(i), 1'b0, 1'b0);
    chk("t6_done_pre", dbg_done, 1);
    chk("t6_pc_pre", dbg_pc, 32'h4008);
    #1 reset = 1'b0;
    #1;
    chk("t6_done_clr", dbg_done, 0);
    chk("t6_wen_clr", dbg_gpr_wen, 0);
    chk("t6_pc_clr", dbg_pc, 0);
    chk("t6_wdata_clr", dbg_gpr_wdata, 0);
    chk("t6_ready", wb_ready, 1);
    repeat (2) @(negedge clk);
    q_pc.delete();
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_no_stale", q_pc.size(), 0);
    push(32'h5000, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_fresh_n", q_pc.size(), 1);
    chk("t6_fresh_pc", (q_pc.size() > 0) ? q_pc[0] : 32'hFFFF_FFFF, 32'h5000);
    chk("gaps_total", b2b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
